// File: rtl/skel_sched_pkg.sv
// Shared types and helpers for the skeleton frame scheduler.
//   sched_state_t : scheduler FSM encoding (also exported on state_out)
//   sat_inc16     : 16-bit saturating increment used by the frame counters
package skel_sched_pkg;

   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      WAIT    = 2'd2,
      RECOVER = 2'd3
   } sched_state_t;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc16(input logic [CNT_W-1:0] value);
      return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
   endfunction

endpackage

// File: rtl/skel_watchdog.sv
// Loadable cycle counter with synchronous clear, count enable and an expire
// strobe that fires in the enabled cycle where the count equals limit.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (highest priority)
//   load       : synchronous load of load_val
//   en         : advance the count by one
//   limit      : terminal count compared against while enabled
//   expire_c   : combinational strobe, en && count == limit
module skel_watchdog #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic [WIDTH-1:0] limit,
   output logic             expire_c
);

   logic [WIDTH-1:0] count;

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= count + WIDTH'(1);
      end
   end

   assign expire_c = en && !clr && (count == limit);

endmodule

// File: rtl/skeleton_frame_scheduler.sv
// Frame admission, decimation, drop accounting and hang recovery in front of
// the skeletonizer; also holds the most recent centre-of-mass result.
//   clk_in, rst_n_in           : clock, asynchronous active-low reset
//   enable_in                  : permit admission of new frames
//   hcount/vcount/pixel/valid  : thresholded camera pixel stream
//   skel_*_out                 : pixel stream and synchronous reset to skeletonizer
//   skel_busy_in, skel_com_*   : skeletonizer status and centre-of-mass result
//   com_*_out                  : latched centre-of-mass, sticky valid, update pulse
//   frames_done/dropped_out    : saturating frame statistics
//   timeout_out, state_out     : sticky watchdog flag, FSM state
module skeleton_frame_scheduler
   import skel_sched_pkg::*;
#(
   parameter  int unsigned HORIZONTAL_COUNT = 320,
   parameter  int unsigned VERTICAL_COUNT   = 180,
   parameter  int unsigned DECIMATE         = 1,
   parameter  int unsigned TIMEOUT_CYCLES   = 4000000,
   parameter  int unsigned RST_CYCLES       = 4,
   localparam int unsigned HWIDTH           = $clog2(HORIZONTAL_COUNT),
   localparam int unsigned VWIDTH           = $clog2(VERTICAL_COUNT)
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              enable_in,
   input  logic [HWIDTH-1:0] hcount_in,
   input  logic [VWIDTH-1:0] vcount_in,
   input  logic              pixel_in,
   input  logic              pixel_valid_in,
   output logic [HWIDTH-1:0] skel_hcount_out,
   output logic [VWIDTH-1:0] skel_vcount_out,
   output logic              skel_pixel_out,
   output logic              skel_pixel_valid_out,
   output logic              skel_rst_out,
   input  logic              skel_busy_in,
   input  logic [HWIDTH-1:0] skel_com_x_in,
   input  logic [VWIDTH-1:0] skel_com_y_in,
   input  logic              skel_com_valid_in,
   output logic [HWIDTH-1:0] com_x_out,
   output logic [VWIDTH-1:0] com_y_out,
   output logic              com_valid_out,
   output logic              com_update_out,
   output logic [15:0]       frames_done_out,
   output logic [15:0]       frames_dropped_out,
   output logic              timeout_out,
   output logic [1:0]        state_out
);

   localparam int unsigned RW = $clog2(RST_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned DW = $clog2(DECIMATE + 1);

   sched_state_t  state;
   logic [DW-1:0] dcnt;
   logic          seen_busy;
   logic          fs;
   logic          fe;
   logic          admit;
   logic          fwd;
   logic          rst_done;
   logic          wait_expired;

   // Frame boundary decode and forwarding decision
   always_comb begin
      fs    = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
      fe    = pixel_valid_in && (hcount_in == HWIDTH'(HORIZONTAL_COUNT - 1))
                             && (vcount_in == VWIDTH'(VERTICAL_COUNT - 1));
      admit = enable_in && (dcnt == '0);
      fwd   = ((state == LOAD) && pixel_valid_in) || ((state == IDLE) && fs && admit);
   end

   // Length of the skeletonizer reset pulse
   skel_watchdog #(.WIDTH(RW)) u_rst_timer (
      .clk      (clk_in),
      .rst_n    (rst_n_in),
      .clr      (state != RECOVER),
      .load     (1'b0),
      .load_val ('0),
      .en       (state == RECOVER),
      .limit    (RW'(RST_CYCLES - 1)),
      .expire_c (rst_done)
   );

   // Bound on how long the skeletonizer may take per frame
   skel_watchdog #(.WIDTH(TW)) u_wait_timer (
      .clk      (clk_in),
      .rst_n    (rst_n_in),
      .clr      (state != WAIT),
      .load     (1'b0),
      .load_val ('0),
      .en       (state == WAIT),
      .limit    (TW'(TIMEOUT_CYCLES - 1)),
      .expire_c (wait_expired)
   );

   // Scheduler FSM with registered outputs
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state                <= RECOVER;
         dcnt                 <= '0;
         seen_busy            <= 1'b0;
         skel_hcount_out      <= '0;
         skel_vcount_out      <= '0;
         skel_pixel_out       <= 1'b0;
         skel_pixel_valid_out <= 1'b0;
         skel_rst_out         <= 1'b1;
         com_x_out            <= '0;
         com_y_out            <= '0;
         com_valid_out        <= 1'b0;
         com_update_out       <= 1'b0;
         frames_done_out      <= '0;
         frames_dropped_out   <= '0;
         timeout_out          <= 1'b0;
      end else begin
         skel_pixel_valid_out <= 1'b0;
         com_update_out       <= 1'b0;

         if (fwd) begin
            skel_hcount_out      <= hcount_in;
            skel_vcount_out      <= vcount_in;
            skel_pixel_out       <= pixel_in;
            skel_pixel_valid_out <= 1'b1;
         end

         // Results produced while the skeletonizer is held in reset are ignored
         if (skel_com_valid_in && (state != RECOVER)) begin
            com_x_out      <= skel_com_x_in;
            com_y_out      <= skel_com_y_in;
            com_valid_out  <= 1'b1;
            com_update_out <= 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (fs) begin
                  dcnt <= (dcnt == DW'(DECIMATE - 1)) ? '0 : dcnt + DW'(1);
                  if (admit) begin
                     state <= LOAD;
                  end else begin
                     frames_dropped_out <= sat_inc16(frames_dropped_out);
                  end
               end
            end
            LOAD: begin
               // A fresh frame start restarts loading; the aborted frame is a drop
               if (fs) begin
                  frames_dropped_out <= sat_inc16(frames_dropped_out);
               end else if (fe) begin
                  state     <= WAIT;
                  seen_busy <= 1'b0;
               end
            end
            WAIT: begin
               if (fs) begin
                  frames_dropped_out <= sat_inc16(frames_dropped_out);
               end
               if (skel_busy_in) begin
                  seen_busy <= 1'b1;
               end
               if (wait_expired) begin
                  timeout_out  <= 1'b1;
                  skel_rst_out <= 1'b1;
                  state        <= RECOVER;
               end else if (seen_busy && !skel_busy_in) begin
                  frames_done_out <= sat_inc16(frames_done_out);
                  state           <= IDLE;
               end
            end
            RECOVER: begin
               if (fs) begin
                  frames_dropped_out <= sat_inc16(frames_dropped_out);
               end
               if (rst_done) begin
                  skel_rst_out <= 1'b0;
                  state        <= IDLE;
               end
            end
         endcase
      end
   end

   assign state_out = 2'(state);

endmodule
